// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Purpose: bundles the two requester channels (A and B) and the data-memory
//          port of the memory arbiter into one interface.
// Ports (signals):
//   aReq/bReq       requester access request
//   aWrite/bWrite   request type, 1 = write, 0 = read
//   aAddr/bAddr     target line (ADDR_W)
//   aWData/bWData   write data (DATA_W)
//   aGnt/bGnt       one-cycle grant pulse
//   aDone/bDone     one-cycle completion pulse
//   aRData/bRData   read-data registers (DATA_W)
//   lineNumber      memory line address (ADDR_W)
//   memIn           data toward memory (DATA_W)
//   memRead         memory read strobe
//   memWrite        memory write strobe
//   memOut          data from memory (DATA_W)
// Modports: slave = arbiter side, master = requesters plus memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              aReq;
  logic              bReq;
  logic              aWrite;
  logic              bWrite;
  logic [ADDR_W-1:0] aAddr;
  logic [ADDR_W-1:0] bAddr;
  logic [DATA_W-1:0] aWData;
  logic [DATA_W-1:0] bWData;
  logic              aGnt;
  logic              bGnt;
  logic              aDone;
  logic              bDone;
  logic [DATA_W-1:0] aRData;
  logic [DATA_W-1:0] bRData;
  logic [ADDR_W-1:0] lineNumber;
  logic [DATA_W-1:0] memIn;
  logic              memRead;
  logic              memWrite;
  logic [DATA_W-1:0] memOut;

  modport slave (
    input  aReq, bReq, aWrite, bWrite, aAddr, bAddr, aWData, bWData, memOut,
    output aGnt, bGnt, aDone, bDone, aRData, bRData,
           lineNumber, memIn, memRead, memWrite
  );

  modport master (
    output aReq, bReq, aWrite, bWrite, aAddr, bAddr, aWData, bWData, memOut,
    input  aGnt, bGnt, aDone, bDone, aRData, bRData,
           lineNumber, memIn, memRead, memWrite
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Purpose: arbitrates two requesters (A, B) onto a single data-memory port.
//          Each accepted request runs IDLE -> ACCESS -> DONE: the grant pulses
//          in ACCESS, the memory strobe is asserted in ACCESS, read data is
//          captured on the ACCESS->DONE edge and the done pulse fires in DONE.
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter_if.slave (requester channels and memory port)
// Configuration:
//   MEM_ARBITER_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                               between A and B using a last-winner flag;
//                               when undefined, A always wins a tie.
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_arbiter_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } stateT;

  stateT             state;
  stateT             nextState;

  // Latched transaction (held outside ACCESS so lineNumber/memIn stay stable).
  logic [ADDR_W-1:0] latchedAddr;
  logic [DATA_W-1:0] latchedWData;
  logic              latchedWrite;
  logic              winnerIsB;

  logic [DATA_W-1:0] aRDataReg;
  logic [DATA_W-1:0] bRDataReg;

  logic              anyReq;
  logic              pickB;

  assign anyReq = bus.aReq | bus.bReq;

  // Winner selection for the current IDLE cycle. A lone requester always
  // wins; only a tie consults the arbitration policy.
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic lastWinnerB;

  always_comb begin
    pickB = bus.bReq & (~bus.aReq | ~lastWinnerB);
  end

  // Last-winner flag: resets to B so the first tie after reset goes to A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastWinnerB <= 1'b1;
    end else if (state == IDLE && anyReq) begin
      lastWinnerB <= pickB;
    end
  end
`else
  always_comb begin
    pickB = bus.bReq & ~bus.aReq;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: requests only matter in IDLE; ACCESS and DONE are
  // fixed one-cycle states.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    nextState = anyReq ? ACCESS : IDLE;
      ACCESS:  nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Transaction latch and read-data capture. The read data is taken from
  // memOut on the ACCESS->DONE edge while the memory sees the latched line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latchedAddr  <= '0;
      latchedWData <= '0;
      latchedWrite <= 1'b0;
      winnerIsB    <= 1'b0;
      aRDataReg    <= '0;
      bRDataReg    <= '0;
    end else begin
      if (state == IDLE && anyReq) begin
        latchedAddr  <= pickB ? bus.bAddr  : bus.aAddr;
        latchedWData <= pickB ? bus.bWData : bus.aWData;
        latchedWrite <= pickB ? bus.bWrite : bus.aWrite;
        winnerIsB    <= pickB;
      end
      if (state == ACCESS && !latchedWrite) begin
        if (winnerIsB) begin
          bRDataReg <= bus.memOut;
        end else begin
          aRDataReg <= bus.memOut;
        end
      end
    end
  end

  // Output decode: strobes, grants and dones come straight from the state,
  // so an asynchronous reset clears them in the same cycle.
  always_comb begin
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.aGnt     = 1'b0;
    bus.bGnt     = 1'b0;
    bus.aDone    = 1'b0;
    bus.bDone    = 1'b0;
    case (state)
      ACCESS: begin
        bus.memRead  = ~latchedWrite;
        bus.memWrite = latchedWrite;
        bus.aGnt     = ~winnerIsB;
        bus.bGnt     = winnerIsB;
      end
      DONE: begin
        bus.aDone = ~winnerIsB;
        bus.bDone = winnerIsB;
      end
      default: begin
      end
    endcase
  end

  assign bus.lineNumber = latchedAddr;
  assign bus.memIn      = latchedWData;
  assign bus.aRData     = aRDataReg;
  assign bus.bRData     = bRDataReg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Purpose: directed self-checking bench for mem_arbiter with a small
//          behavioural memory (combinational read, write on rising edge).
// Expected grant order on tied requests depends on
// MEM_ARBITER_ROUND_ROBIN_EN, mirroring the build of the design.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  logic [7:0] mem [256];

  mem_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: line i starts as i ^ 0xC3.
  assign bus.memOut = mem[bus.lineNumber];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'hC3;
    end
    forever begin
      @(posedge clk);
      if (bus.memWrite) begin
        mem[bus.lineNumber] <= bus.memIn;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic aR, input logic aW,
                               input logic [7:0] aA, input logic [7:0] aD,
                               input logic bR, input logic bW,
                               input logic [7:0] bA, input logic [7:0] bD);
    bus.aReq   = aR;
    bus.aWrite = aW;
    bus.aAddr  = aA;
    bus.aWData = aD;
    bus.bReq   = bR;
    bus.bWrite = bW;
    bus.bAddr  = bA;
    bus.bWData = bD;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".aGnt"},       32'(bus.aGnt),       32'h0);
    checkOutput({tag, ".bGnt"},       32'(bus.bGnt),       32'h0);
    checkOutput({tag, ".aDone"},      32'(bus.aDone),      32'h0);
    checkOutput({tag, ".bDone"},      32'(bus.bDone),      32'h0);
    checkOutput({tag, ".memRead"},    32'(bus.memRead),    32'h0);
    checkOutput({tag, ".memWrite"},   32'(bus.memWrite),   32'h0);
    checkOutput({tag, ".lineNumber"}, 32'(bus.lineNumber), 32'h0);
    checkOutput({tag, ".memIn"},      32'(bus.memIn),      32'h0);
    checkOutput({tag, ".aRData"},     32'(bus.aRData),     32'h0);
    checkOutput({tag, ".bRData"},     32'(bus.bRData),     32'h0);
  endtask

  int gntCount;
  int gntWho [4];
  int gntCyc [4];
  int bothHigh;
  int bGntSeen;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("reset");

    // A writes 0x5A to line 0x10; request presented with reset release so the
    // first edge out of reset accepts it.
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    bus.aReq = 1'b0;
    @(negedge clk);
    checkOutput("wrA.aGnt",       32'(bus.aGnt),       32'h1);
    checkOutput("wrA.bGnt",       32'(bus.bGnt),       32'h0);
    checkOutput("wrA.memWrite",   32'(bus.memWrite),   32'h1);
    checkOutput("wrA.memRead",    32'(bus.memRead),    32'h0);
    checkOutput("wrA.lineNumber", 32'(bus.lineNumber), 32'h10);
    checkOutput("wrA.memIn",      32'(bus.memIn),      32'h5A);
    @(posedge clk);
    @(negedge clk);
    checkOutput("wrA.aDone",      32'(bus.aDone),      32'h1);
    checkOutput("wrA.bDone",      32'(bus.bDone),      32'h0);
    checkOutput("wrA.gntDropped", 32'(bus.aGnt),       32'h0);
    checkOutput("wrA.memWrOff",   32'(bus.memWrite),   32'h0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("wrA.doneOnce",   32'(bus.aDone),      32'h0);
    checkOutput("wrA.lineHold",   32'(bus.lineNumber), 32'h10);
    checkOutput("wrA.memInHold",  32'(bus.memIn),      32'h5A);

    // B reads line 0x10 back.
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00);
    @(posedge clk); #1;
    bus.bReq = 1'b0;
    @(negedge clk);
    checkOutput("rdB.bGnt",    32'(bus.bGnt),    32'h1);
    checkOutput("rdB.aGnt",    32'(bus.aGnt),    32'h0);
    checkOutput("rdB.memRead", 32'(bus.memRead), 32'h1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rdB.bDone",   32'(bus.bDone),   32'h1);
    checkOutput("rdB.bRData",  32'(bus.bRData),  32'h5A);
    checkOutput("rdB.aRData",  32'(bus.aRData),  32'h0);

    // Both requesters held high: reads of lines 0x01 (A) and 0x02 (B).
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
    gntCount = 0;
    bothHigh = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      @(negedge clk);
      if ((bus.aGnt && bus.bGnt) || (bus.aDone && bus.bDone) ||
          ((bus.aGnt || bus.bGnt) && (bus.aDone || bus.bDone))) begin
        bothHigh++;
      end
      if ((bus.aGnt || bus.bGnt) && gntCount < 4) begin
        gntWho[gntCount] = bus.bGnt ? 1 : 0;
        gntCyc[gntCount] = c;
        gntCount++;
      end
    end
    checkOutput("tie.count",   32'(gntCount), 32'd4);
    checkOutput("tie.overlap", 32'(bothHigh), 32'd0);
    checkOutput("tie.first",   32'(gntCyc[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      checkOutput($sformatf("tie.who%0d", i), 32'(gntWho[i]), 32'(i % 2));
`else
      checkOutput($sformatf("tie.who%0d", i), 32'(gntWho[i]), 32'd0);
`endif
      if (i > 0) begin
        checkOutput($sformatf("tie.gap%0d", i), 32'(gntCyc[i] - gntCyc[i-1]), 32'd3);
      end
    end

    // Reset during the ACCESS of a write to line 0x20.
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 8'h20, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk); #1;
    bus.aReq = 1'b0;
    @(negedge clk);
    checkOutput("abort.preWrite", 32'(bus.memWrite), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort.noADone", 32'(bus.aDone), 32'h0);
    checkOutput("abort.noBDone", 32'(bus.bDone), 32'h0);

    // A reads line 0xFF; B pulses its request only during ACCESS.
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h33, 8'h00);
    @(posedge clk); #1;
    bus.aReq = 1'b0;
    bus.bReq = 1'b1;
    @(negedge clk);
    checkOutput("rdFF.aGnt",    32'(bus.aGnt),       32'h1);
    checkOutput("rdFF.memRead", 32'(bus.memRead),    32'h1);
    checkOutput("rdFF.line",    32'(bus.lineNumber), 32'hFF);
    bGntSeen = 0;
    @(posedge clk); #1;
    bus.bReq = 1'b0;
    @(negedge clk);
    checkOutput("rdFF.aDone",  32'(bus.aDone),  32'h1);
    checkOutput("rdFF.aRData", 32'(bus.aRData), 32'h3C);
    for (int c = 0; c < 5; c++) begin
      if (bus.bGnt) bGntSeen++;
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("rdFF.bNeverGnt", 32'(bGntSeen), 32'd0);
    checkOutput("rdFF.bRDataHold", 32'(bus.bRData), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the memory line-number width.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the memory word width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports aReq / bReq, input, 1, requester A / B access request.
REQ-006 The block SHALL have ports aWrite / bWrite, input, 1, request type (1 write, 0 read).
REQ-007 The block SHALL have ports aAddr / bAddr, input, ADDR_W, target line.
REQ-008 The block SHALL have ports aWData / bWData, input, DATA_W, write data.
REQ-009 The block SHALL have ports aGnt / bGnt, output, 1, one-cycle grant pulse.
REQ-010 The block SHALL have ports aDone / bDone, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have ports aRData / bRData, output, DATA_W, read-data registers.
REQ-012 The block SHALL have ports lineNumber (output, ADDR_W), memIn (output, DATA_W), memRead (output, 1), memWrite (output, 1) and memOut (input, DATA_W), connecting to the data memory.

Function
REQ-013 The block SHALL implement FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-014 In IDLE, the block SHALL sample aReq and bReq at each edge; if any is high it SHALL latch the winner's addr, wdata, write and identity, then go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-015 ACCESS SHALL last exactly one cycle: lineNumber = latched addr, memIn = latched wdata, memRead = !write, memWrite = write, winner's Gnt = 1.
REQ-016 At the ACCESS->DONE edge, for a read, the winner's RData SHALL capture memOut; the loser's RData and all RData on writes SHALL hold.
REQ-017 DONE SHALL last one cycle with the winner's Done = 1, then return to IDLE unconditionally.
REQ-018 Latency SHALL be: request sampled at edge N, Gnt high cycle N+1, Done high cycle N+2, next acceptance possible at edge N+3.
REQ-019 Requests SHALL be ignored in ACCESS and DONE; a Req still high in IDLE SHALL start a new transaction, so a requester must drop Req on seeing its Gnt to avoid a repeat.
REQ-020 memRead and memWrite SHALL be 0 outside ACCESS; they SHALL never both be 1.
REQ-021 lineNumber and memIn SHALL hold their latched values outside ACCESS.
REQ-022 Gnt and Done SHALL be one-hot-or-zero across A/B and SHALL never be high in the same cycle.
REQ-023 If one requester alone is high in IDLE, it SHALL win regardless of arbitration history.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE; Gnt, Done, memRead and memWrite to 0; lineNumber, memIn, aRData and bRData to 0; the last-winner flag to B.
REQ-025 Reset during ACCESS SHALL abort the transaction within the same cycle with no Done pulse; memory contents are not restored.
REQ-026 The first edge with rst_n high SHALL be able to accept a request.

Configuration
REQ-027 With MEM_ARBITER_ROUND_ROBIN_EN defined, on simultaneous aReq and bReq the winner SHALL be the requester other than the last winner, and the last-winner flag SHALL update on each acceptance.
REQ-028 Without MEM_ARBITER_ROUND_ROBIN_EN, A SHALL always win simultaneous requests and the last-winner flag SHALL be absent or unused.

Verification
REQ-029 Reset, then A writes 0x5A to line 0x10 -> aGnt cycle 1 with memWrite = 1 and lineNumber = 0x10, aDone cycle 2, bGnt and bDone stay 0.
REQ-030 After REQ-029, B reads line 0x10 -> bRData = 0x5A at the bDone cycle, aRData unchanged.
REQ-031 With round-robin defined, aReq and bReq held high continuously -> grant order A, B, A, B, with a 3-cycle spacing between grants.
REQ-032 Without the macro, the REQ-031 stimulus -> every grant goes to A and B is starved.
REQ-033 rst_n pulsed low during ACCESS of a write -> memWrite drops immediately, no Done, and all outputs equal their reset values.
REQ-034 A reads line 0xFF while bReq rises during ACCESS and drops before IDLE -> B is never granted, and aRData equals the memory value at 0xFF.
